// File: rtl/fsm_req_gen_if.sv
// rtl/fsm_req_gen_if.sv - request/grant and beat bus between fsm_req_gen and the arbiter side
interface fsm_req_gen_if;
  logic       req_0;
  logic       req_1;
  logic       req_2;
  logic       req_3;
  logic       gnt_0;
  logic       gnt_1;
  logic       gnt_2;
  logic       gnt_3;
  logic       xfer_valid;
  logic [1:0] xfer_agent;
  logic       xfer_last;

  modport master (
    output req_0, req_1, req_2, req_3,
    output xfer_valid, xfer_agent, xfer_last,
    input  gnt_0, gnt_1, gnt_2, gnt_3
  );

  modport slave (
    input  req_0, req_1, req_2, req_3,
    input  xfer_valid, xfer_agent, xfer_last,
    output gnt_0, gnt_1, gnt_2, gnt_3
  );
endinterface

// File: rtl/fsm_req_gen.sv
// rtl/fsm_req_gen.sv - four-agent request front-end for a fixed-priority grant FSM
module fsm_req_gen #(
  parameter int BURST_W = 4,
  parameter int CNT_W   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         job_push,
  input  logic [BURST_W-1:0] cfg_burst_len,
  fsm_req_gen_if.master      bus,
  output logic [3:0]         job_full,
  output logic [3:0]         job_drop,
  output logic               protocol_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_t             state_q [4];
  state_t             state_d [4];
  logic [CNT_W-1:0]   pend_q  [4];
  logic [CNT_W-1:0]   pend_d  [4];
  logic [BURST_W-1:0] beat_q  [4];
  logic [BURST_W-1:0] beat_d  [4];
  logic [3:0]         req_q;
  logic [3:0]         req_d;
  logic [3:0]         drop_q;
  logic [3:0]         drop_d;
  logic               err_q;
  logic               err_set;

  logic [3:0]         gnt;
  logic [3:0]         beat;
  logic [3:0]         pop;
  logic [3:0]         idle_vec;
  logic [BURST_W-1:0] burst_load;

  assign gnt = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};

  // A zero burst length is treated as a single beat.
  assign burst_load = (cfg_burst_len == '0) ? '0 : cfg_burst_len - BURST_W'(1);

  // Per-agent beat qualification and job completion decode.
  always_comb begin
    beat     = '0;
    pop      = '0;
    idle_vec = '0;
    for (int n = 0; n < 4; n++) begin
      beat[n]     = (state_q[n] == XFER) && gnt[n];
      pop[n]      = beat[n] && (beat_q[n] == '0);
      idle_vec[n] = (state_q[n] == IDLE);
    end
  end

  // State, counters, registered request and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= IDLE;
        pend_q[n]  <= '0;
        beat_q[n]  <= '0;
      end
      req_q  <= '0;
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= state_d[n];
        pend_q[n]  <= pend_d[n];
        beat_q[n]  <= beat_d[n];
      end
      req_q  <= req_d;
      drop_q <= drop_d;
      err_q  <= err_q | err_set;
    end
  end

  // Next state, pending/beat counter updates and error detection.
  always_comb begin
    drop_d  = '0;
    req_d   = '0;
    err_set = ((gnt & (gnt - 4'd1)) != 4'd0) || ((gnt & idle_vec) != 4'd0);
    for (int n = 0; n < 4; n++) begin
      state_d[n] = state_q[n];
      beat_d[n]  = beat_q[n];
      pend_d[n]  = pend_q[n];

      // A full counter still accepts a push when a pop frees a slot this cycle.
      if (job_push[n] && !pop[n]) begin
        if (pend_q[n] == PEND_MAX) begin
          drop_d[n] = 1'b1;
        end else begin
          pend_d[n] = pend_q[n] + CNT_W'(1);
        end
      end else if (!job_push[n] && pop[n]) begin
        pend_d[n] = pend_q[n] - CNT_W'(1);
      end

      case (state_q[n])
        IDLE: begin
          if (pend_d[n] != '0) state_d[n] = REQ;
        end
        REQ: begin
          if (gnt[n]) begin
            state_d[n] = XFER;
            beat_d[n]  = burst_load;
          end
        end
        XFER: begin
          if (beat[n]) begin
            if (beat_q[n] == '0) state_d[n] = REL;
            else                 beat_d[n]  = beat_q[n] - BURST_W'(1);
          end
        end
        default: begin
          if (!gnt[n]) state_d[n] = (pend_d[n] != '0) ? REQ : IDLE;
        end
      endcase

      req_d[n] = (state_d[n] == REQ) || (state_d[n] == XFER);
    end
  end

  // Beat outputs follow gnt combinationally; the lowest qualifying agent owns the bus.
  always_comb begin
    bus.xfer_valid = 1'b0;
    bus.xfer_agent = 2'd0;
    bus.xfer_last  = 1'b0;
    for (int n = 3; n >= 0; n--) begin
      if (beat[n]) begin
        bus.xfer_valid = 1'b1;
        bus.xfer_agent = 2'(n);
        bus.xfer_last  = (beat_q[n] == '0);
      end
    end
  end

  assign bus.req_0 = req_q[0];
  assign bus.req_1 = req_q[1];
  assign bus.req_2 = req_q[2];
  assign bus.req_3 = req_q[3];

  assign job_full     = {pend_q[3] == PEND_MAX, pend_q[2] == PEND_MAX,
                         pend_q[1] == PEND_MAX, pend_q[0] == PEND_MAX};
  assign job_drop     = drop_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_fsm_req_gen.sv
// tb/tb_fsm_req_gen.sv - directed self-checking bench for fsm_req_gen
module tb_fsm_req_gen;
  logic       clock;
  logic       reset;
  logic [3:0] job_push;
  logic [3:0] cfg_burst_len;
  logic [3:0] job_full;
  logic [3:0] job_drop;
  logic       protocol_err;
  int         checks;
  int         errors;

  fsm_req_gen_if bus ();

  fsm_req_gen #(.BURST_W(4), .CNT_W(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .job_push      (job_push),
    .cfg_burst_len (cfg_burst_len),
    .bus           (bus),
    .job_full      (job_full),
    .job_drop      (job_drop),
    .protocol_err  (protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic set_gnt(input logic [3:0] g);
    bus.gnt_0 = g[0];
    bus.gnt_1 = g[1];
    bus.gnt_2 = g[2];
    bus.gnt_3 = g[3];
  endtask

  function automatic logic [3:0] req_vec();
    return {bus.req_3, bus.req_2, bus.req_1, bus.req_0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic [1:0] a, input logic l);
    chk({tag, "_valid"}, 32'(bus.xfer_valid), 32'(v));
    chk({tag, "_agent"}, 32'(bus.xfer_agent), 32'(a));
    chk({tag, "_last"},  32'(bus.xfer_last),  32'(l));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    job_push      = 4'b0000;
    cfg_burst_len = 4'd0;
    set_gnt(4'b0000);

    // Reset state
    cyc();
    cyc();
    chk("rst_req", 32'(req_vec()), 32'h0);
    chk_beat("rst", 1'b0, 2'd0, 1'b0);
    chk("rst_full", 32'(job_full), 32'h0);
    chk("rst_drop", 32'(job_drop), 32'h0);
    chk("rst_err", 32'(protocol_err), 32'h0);
    reset = 1'b0;

    // Test 1: single agent0 burst of 3, grant two cycles after request
    cfg_burst_len = 4'd3;
    job_push = 4'b0001;
    #1 chk("t1_req_before", 32'(req_vec()), 32'h0);
    cyc(); job_push = 4'b0000;
    #1 chk("t1_req_rise", 32'(req_vec()), 32'h1);
    cyc();
    #1 chk("t1_wait_valid", 32'(bus.xfer_valid), 32'h0);
    cyc(); set_gnt(4'b0001);
    #1 chk("t1_gnt_in_req", 32'(bus.xfer_valid), 32'h0);
    cyc();
    #1 chk_beat("t1_b1", 1'b1, 2'd0, 1'b0);
    cyc();
    #1 chk_beat("t1_b2", 1'b1, 2'd0, 1'b0);
    cyc();
    #1 chk_beat("t1_b3", 1'b1, 2'd0, 1'b1);
    cyc(); set_gnt(4'b0000);
    #1 chk("t1_req_fall", 32'(req_vec()), 32'h0);
    chk("t1_rel_valid", 32'(bus.xfer_valid), 32'h0);
    cyc();
    #1 chk("t1_pend0", 32'(dut.pend_q[0]), 32'h0);
    chk("t1_err", 32'(protocol_err), 32'h0);

    // Test 2: agents 1 and 3 together, len 2, arbiter serves 1 then 3
    cfg_burst_len = 4'd2;
    job_push = 4'b1010;
    cyc(); job_push = 4'b0000;
    #1 chk("t2_req", 32'(req_vec()), 32'ha);
    cyc(); set_gnt(4'b0010);
    #1 chk("t2_gnt1_req", 32'(bus.xfer_valid), 32'h0);
    cyc();
    #1 chk_beat("t2_a1b1", 1'b1, 2'd1, 1'b0);
    chk("t2_req_hold", 32'(req_vec()), 32'ha);
    cyc();
    #1 chk_beat("t2_a1b2", 1'b1, 2'd1, 1'b1);
    cyc(); set_gnt(4'b0000);
    #1 chk("t2_req_after1", 32'(req_vec()), 32'h8);
    chk("t2_gap_valid", 32'(bus.xfer_valid), 32'h0);
    cyc(); set_gnt(4'b1000);
    #1 chk("t2_gnt3_req", 32'(bus.xfer_valid), 32'h0);
    cyc();
    #1 chk_beat("t2_a3b1", 1'b1, 2'd3, 1'b0);
    cyc();
    #1 chk_beat("t2_a3b2", 1'b1, 2'd3, 1'b1);
    cyc(); set_gnt(4'b0000);
    #1 chk("t2_req_end", 32'(req_vec()), 32'h0);
    chk("t2_err", 32'(protocol_err), 32'h0);

    // Test 4: two queued single-beat jobs for agent0, req held low until gnt falls
    cfg_burst_len = 4'd1;
    job_push = 4'b0001;
    cyc();
    #1 chk("t4_req1", 32'(req_vec()), 32'h1);
    cyc(); job_push = 4'b0000; set_gnt(4'b0001);
    cyc();
    #1 chk_beat("t4_j1", 1'b1, 2'd0, 1'b1);
    cyc();
    #1 chk("t4_req_low_gnt_high", 32'(req_vec()), 32'h0);
    cyc(); set_gnt(4'b0000);
    #1 chk("t4_req_low_gnt_low", 32'(req_vec()), 32'h0);
    cyc(); set_gnt(4'b0001);
    #1 chk("t4_req2", 32'(req_vec()), 32'h1);
    cyc();
    #1 chk_beat("t4_j2", 1'b1, 2'd0, 1'b1);
    cyc(); set_gnt(4'b0000);
    #1 chk("t4_req_end", 32'(req_vec()), 32'h0);
    cyc();
    #1 chk("t4_pend0", 32'(dut.pend_q[0]), 32'h0);
    chk("t4_idle_req", 32'(req_vec()), 32'h0);

    // Test 3: agent2 saturates at 3 pending, 4th push dropped
    job_push = 4'b0100;
    cyc();
    cyc();
    #1 chk("t3_full_at2", 32'(job_full), 32'h0);
    cyc();
    #1 chk("t3_full_at3", 32'(job_full), 32'h4);
    chk("t3_drop_before", 32'(job_drop), 32'h0);
    cyc(); job_push = 4'b0000;
    #1 chk("t3_drop_pulse", 32'(job_drop), 32'h4);
    chk("t3_pend_sat", 32'(dut.pend_q[2]), 32'h3);
    chk("t3_full_hold", 32'(job_full), 32'h4);
    cyc();
    #1 chk("t3_drop_clear", 32'(job_drop), 32'h0);

    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    #1 chk("t3_rst_full", 32'(job_full), 32'h0);
    chk("t3_rst_pend", 32'(dut.pend_q[2]), 32'h0);
    chk("t3_rst_req", 32'(req_vec()), 32'h0);

    // Test 5: reset during beat 2 of a 4-beat burst
    cfg_burst_len = 4'd4;
    job_push = 4'b0001;
    cyc(); job_push = 4'b0000; set_gnt(4'b0001);
    #1 chk("t5_req", 32'(req_vec()), 32'h1);
    cyc();
    #1 chk_beat("t5_b1", 1'b1, 2'd0, 1'b0);
    cyc(); reset = 1'b1;
    #1 chk_beat("t5_b2", 1'b1, 2'd0, 1'b0);
    cyc(); reset = 1'b0; set_gnt(4'b0000);
    #1 chk("t5_req_clr", 32'(req_vec()), 32'h0);
    chk_beat("t5_after", 1'b0, 2'd0, 1'b0);
    chk("t5_pend_clr", 32'(dut.pend_q[0]), 32'h0);
    chk("t5_err", 32'(protocol_err), 32'h0);
    cyc();
    #1 chk("t5_no_rereq", 32'(req_vec()), 32'h0);

    // Burst length 0 is one beat
    cfg_burst_len = 4'd0;
    job_push = 4'b0010;
    cyc(); job_push = 4'b0000; set_gnt(4'b0010);
    #1 chk("len0_req", 32'(req_vec()), 32'h2);
    cyc();
    #1 chk_beat("len0_b1", 1'b1, 2'd1, 1'b1);
    cyc(); set_gnt(4'b0000);
    #1 chk("len0_req_fall", 32'(req_vec()), 32'h0);
    chk("len0_rel_valid", 32'(bus.xfer_valid), 32'h0);

    // Test 6a: gnt_2 while agent2 is idle
    cyc(); set_gnt(4'b0100);
    #1 chk("t6a_err_pre", 32'(protocol_err), 32'h0);
    cyc(); set_gnt(4'b0000);
    #1 chk("t6a_err_set", 32'(protocol_err), 32'h1);
    cyc();
    cyc();
    #1 chk("t6a_err_sticky", 32'(protocol_err), 32'h1);
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    #1 chk("t6a_err_rst", 32'(protocol_err), 32'h0);

    // Test 6b: two grants at once to requesting agents 0 and 1
    cfg_burst_len = 4'd2;
    job_push = 4'b0011;
    cyc(); job_push = 4'b0000; set_gnt(4'b0011);
    #1 chk("t6b_req", 32'(req_vec()), 32'h3);
    chk("t6b_err_pre", 32'(protocol_err), 32'h0);
    cyc();
    #1 chk("t6b_err_set", 32'(protocol_err), 32'h1);
    chk_beat("t6b_prio", 1'b1, 2'd0, 1'b0);
    cyc(); set_gnt(4'b0000); reset = 1'b1;
    cyc(); reset = 1'b0;
    #1 chk("t6b_err_rst", 32'(protocol_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
